// File: rtl/affine2_pkg.sv
// Shared widths and FSM encoding for the affine2 output stage.
// The stage-2 adder and the argmax block both take their score width from here.
package affine2_pkg;

    localparam int unsigned AFF2_DW   = 9;
    localparam int unsigned AFF2_NOUT = 10;
    localparam int unsigned AFF2_IW   = $clog2(AFF2_NOUT);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StAccum = 2'd1,
        StHold  = 2'd2
    } aff2_state_e;

endpackage

// File: rtl/affine2_smax.sv
// Signed running-max selector: picks the (value, index) pair that survives one compare.
// Strict greater-than keeps the earlier index on ties.
module affine2_smax #(
    parameter int unsigned DW = 9,
    parameter int unsigned IW = 4
) (
    input  logic                 first,
    input  logic signed [DW-1:0] cur_val,
    input  logic        [IW-1:0] cur_idx,
    input  logic signed [DW-1:0] new_val,
    input  logic        [IW-1:0] new_idx,
    output logic signed [DW-1:0] sel_val,
    output logic        [IW-1:0] sel_idx
);

    logic take_new;

    always_comb begin
        take_new = first || (new_val > cur_val);
        sel_val  = cur_val;
        sel_idx  = cur_idx;
        if (take_new) begin
            sel_val = new_val;
            sel_idx = new_idx;
        end
    end

endmodule

// File: rtl/affine2_argmax.sv
// Final classification stage: streams N_OUT signed scores per frame, tracks the
// maximum and its index, and holds the winner on a valid/ready output.
module affine2_argmax
    import affine2_pkg::*;
#(
    parameter int unsigned N_OUT = AFF2_NOUT,
    parameter int unsigned DW    = AFF2_DW,
    parameter int unsigned IW    = AFF2_IW
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [DW-1:0] data_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic        [IW-1:0] class_out,
    output logic signed [DW-1:0] max_out,
    output logic                 busy
);

    localparam logic [IW-1:0] LAST_IDX = IW'(N_OUT - 1);

    aff2_state_e          state;
    logic        [IW-1:0] cnt;
    logic signed [DW-1:0] max_r;
    logic        [IW-1:0] idx_r;

    logic                 first_beat;
    logic signed [DW-1:0] sel_val;
    logic        [IW-1:0] sel_idx;

    assign first_beat = (cnt == '0);

    affine2_smax #(
        .DW (DW),
        .IW (IW)
    ) u_smax (
        .first   (first_beat),
        .cur_val (max_r),
        .cur_idx (idx_r),
        .new_val (data_in),
        .new_idx (cnt),
        .sel_val (sel_val),
        .sel_idx (sel_idx)
    );

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state <= StIdle;
            cnt   <= '0;
            max_r <= '0;
            idx_r <= '0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (start) begin
                        state <= StAccum;
                        cnt   <= '0;
                    end
                end
                StAccum: begin
                    // in_ready is high throughout ACCUM, so in_valid alone marks a beat.
                    if (in_valid) begin
                        max_r <= sel_val;
                        idx_r <= sel_idx;
                        if (cnt == LAST_IDX) begin
                            state <= StHold;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                StHold: begin
                    if (out_ready) begin
                        state <= StIdle;
                    end
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

    // Handshake flags decode from the state register only; no input reaches an output.
    assign in_ready  = (state == StAccum);
    assign out_valid = (state == StHold);
    assign busy      = (state != StIdle);
    assign class_out = idx_r;
    assign max_out   = max_r;

endmodule

// File: tb/tb_affine2_argmax.sv
// Scoreboard bench for affine2_argmax: stimulus pushes hand-computed results,
// a negedge monitor compares them against every cycle out_valid is high.
module tb_affine2_argmax;
    import affine2_pkg::*;

    localparam int unsigned NO = AFF2_NOUT;

    typedef logic signed [AFF2_DW-1:0] score_t;
    typedef score_t frame_t [NO];
    typedef struct {
        int cls;
        int mx;
    } exp_t;

    logic               clock = 1'b0;
    logic               reset_n = 1'b0;
    logic               start = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    score_t             data_in = '0;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic [AFF2_IW-1:0] class_out;
    score_t             max_out;
    logic               busy;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass = 0;
    int   n_hs = 0;

    affine2_argmax dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .start     (start),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_in   (data_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .class_out (class_out),
        .max_out   (max_out),
        .busy      (busy)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, req);
    endtask

    // Monitor: while the result is presented it must match the oldest expectation.
    always @(negedge clock) begin
        if (reset_n && out_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_out_valid", 1, 0);
            end else begin
                check("class_out", int'(class_out), sb[0].cls);
                check("max_out", int'(max_out), sb[0].mx);
                if (out_ready) begin
                    void'(sb.pop_front());
                    n_hs++;
                end
            end
        end
    end

    task automatic tick(inout int lat);
        @(posedge clock);
        #1;
        lat++;
    endtask

    task automatic run_frame(input frame_t s, input int exp_cls, input int exp_mx,
                             input bit bubbles, input int stall, input bit junk,
                             input bit check_lat);
        int lat = 0;
        int t = 0;
        if (junk) begin
            in_valid = 1'b1;
            data_in  = 9'sd100;
            repeat (3) tick(lat);
        end
        start = 1'b1;
        sb.push_back('{cls: exp_cls, mx: exp_mx});
        lat = 0;
        tick(lat);
        start    = 1'b0;
        in_valid = 1'b0;
        for (int i = 0; i < int'(NO); i++) begin
            if (bubbles) begin
                repeat ($urandom_range(0, 2)) begin
                    data_in = 9'sd255;
                    tick(lat);
                end
            end
            in_valid = 1'b1;
            data_in  = s[i];
            if (junk && i == 5) start = 1'b1;
            tick(lat);
            start    = 1'b0;
            in_valid = 1'b0;
            data_in  = 9'sd255;
        end
        while (!out_valid && t < 50) begin
            tick(lat);
            t++;
        end
        check("out_valid_seen", int'(out_valid), 1);
        if (check_lat) check("latency", lat, int'(NO) + 1);
        for (int k = 0; k < stall; k++) begin
            if (junk && k == 0) start = 1'b1;
            tick(lat);
            start = 1'b0;
        end
        out_ready = 1'b1;
        tick(lat);
        out_ready = 1'b0;
        check("idle_after_hs_busy", int'(busy), 0);
        check("idle_after_hs_valid", int'(out_valid), 0);
    endtask

    initial begin
        frame_t f_nom = '{3, -5, 20, 7, 0, -256, 19, 255, 1, 2};
        frame_t f_tie = '{-256, -256, -256, -256, -1, -256, -256, -256, -1, -256};
        frame_t f_neg = '{-256, -256, -256, -256, -256, -256, -256, -256, -256, -256};
        frame_t f_bub = '{50, -50, 60, 60, 10, -1, 59, 0, 0, -100};
        frame_t f_ign = '{-7, 12, 99, 98, 99, -100, 0, 5, 6, 7};
        frame_t f_rst = '{-10, -20, -5, -30, -40, -50, -60, -70, -80, -90};
        int dummy = 0;

        repeat (2) @(posedge clock);
        #1;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_class", int'(class_out), 0);
        check("rst_max", int'(max_out), 0);
        reset_n = 1'b1;
        tick(dummy);

        // Three frames back to back, start in the cycle after each handshake.
        run_frame(f_nom, 7, 255, 1'b0, 0, 1'b0, 1'b1);
        run_frame(f_tie, 4, -1, 1'b0, 0, 1'b0, 1'b1);
        run_frame(f_neg, 0, -256, 1'b0, 0, 1'b0, 1'b1);

        run_frame(f_bub, 2, 60, 1'b1, 5, 1'b0, 1'b0);
        run_frame(f_ign, 2, 99, 1'b0, 3, 1'b1, 1'b0);

        // Partial frame of large scores, then reset discards it.
        start = 1'b1;
        tick(dummy);
        start = 1'b0;
        check("accum_in_ready", int'(in_ready), 1);
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            data_in  = score_t'(200 - i);
            tick(dummy);
        end
        in_valid = 1'b0;
        reset_n  = 1'b0;
        tick(dummy);
        check("midrst_out_valid", int'(out_valid), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_in_ready", int'(in_ready), 0);
        check("midrst_class", int'(class_out), 0);
        check("midrst_max", int'(max_out), 0);
        reset_n = 1'b1;
        tick(dummy);
        run_frame(f_rst, 2, -5, 1'b0, 1, 1'b0, 1'b1);

        repeat (3) tick(dummy);
        check("handshakes", n_hs, 6);
        check("scoreboard_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
